// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   Multi-cycle data memory slave for a simple pipelined core. The control
//   path raises a load or store request. The block holds the pipeline (stall)
//   for WAIT_CYCLES wait states plus the capture and response cycles. It then
//   performs the access on a word-organised big-endian store and pulses done.
//   If the access was illegal, it also pulses err_out together with done.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states, 0..15
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset (memory contents kept)
//   re_in, we_in   load / store request (both high = erroring store)
//   size_in        store size: 0 byte, 1 half, 3 word, 2 reserved (error)
//   lbsigned_in, lbunsigned_in, lhsigned_in, lhunsigned_in
//                  load type, priority in that order; none set = word load
//   addr           byte address; only the low log2(DEPTH_WORDS)+2 bits are used
//   wdata          store data, byte/half right-justified
//   rdata          last load result, held until the next completed load
//   stall          pipeline hold while a request is being serviced
//   done           one-cycle completion pulse
//   err_out        one-cycle error pulse, coincident with done
//
// Optional feature:
//   DMEM_MISALIGN_CHECK_EN  when defined, misaligned half/word accesses are
//                           rejected (no write, load returns 0, err_out).
//                           When undefined, the low address bits are ignored
//                           and the access is silently aligned.
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re_in,
  input  logic        we_in,
  input  logic [1:0]  size_in,
  input  logic        lbsigned_in,
  input  logic        lbunsigned_in,
  input  logic        lhsigned_in,
  input  logic        lhunsigned_in,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [2:0] {LD_WORD, LD_BS, LD_BU, LD_HS, LD_HU} ld_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  ld_t           ld_q, ld_d;
  logic          store_q, store_d;
  logic          conflict_q, conflict_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Address bits above the wrap boundary are intentionally ignored.
  logic addr_unused;
  assign addr_unused = ^addr[31:AW+2];

  // ------------------------------------------------------------------
  // Access decode from the captured request
  // ------------------------------------------------------------------
  logic [AW-1:0] idx;
  logic [1:0]    byte_off;
  logic          acc_half, acc_word, misaligned;
  logic          align_err, size_err, acc_err;
  logic          fire, mem_we;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_val;

  assign idx      = addr_q[AW+1:2];
  assign byte_off = addr_q[1:0];

  always_comb begin
    acc_half = 1'b0;
    acc_word = 1'b0;
    if (store_q) begin
      acc_half = (size_q == 2'd1);
      acc_word = (size_q == 2'd3);
    end else begin
      acc_half = (ld_q == LD_HS) || (ld_q == LD_HU);
      acc_word = (ld_q == LD_WORD);
    end
  end

  assign misaligned = (acc_half && addr_q[0]) || (acc_word && (addr_q[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign align_err = misaligned;
`else
  // Misalignment is absorbed by the lane decode, which ignores addr[0] for
  // halves and addr[1:0] for words.
  logic misaligned_unused;
  assign misaligned_unused = misaligned;
  assign align_err = 1'b0;
`endif

  assign size_err = store_q && (size_q == 2'd2);
  assign acc_err  = align_err || size_err || conflict_q;

  // The access executes on the last WAIT cycle.
  assign fire   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign mem_we = fire && store_q && !align_err && !size_err;

  // Byte enables: be[3] covers bits 31:24, i.e. byte offset 0 (big-endian).
  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_q;
    case (size_q)
      2'd0: begin
        be     = 4'b1000 >> byte_off;
        wlanes = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be     = addr_q[1] ? 4'b0011 : 4'b1100;
        wlanes = {2{wdata_q[15:0]}};
      end
      2'd3: begin
        be     = 4'b1111;
        wlanes = wdata_q;
      end
      default: begin
        be     = 4'b0000;
        wlanes = wdata_q;
      end
    endcase
  end

  // One byte-wide array per lane so that partial stores need no
  // read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (mem_we && be[gi]) begin
          lane_mem[idx] <= wlanes[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[idx];
    end
  endgenerate

  always_comb begin
    rd_byte = rd_word[31:24];
    case (byte_off)
      2'd0:    rd_byte = rd_word[31:24];
      2'd1:    rd_byte = rd_word[23:16];
      2'd2:    rd_byte = rd_word[15:8];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  assign rd_half = addr_q[1] ? rd_word[15:0] : rd_word[31:16];

  always_comb begin
    ld_val = rd_word;
    case (ld_q)
      LD_BS:   ld_val = {{24{rd_byte[7]}}, rd_byte};
      LD_BU:   ld_val = {24'd0, rd_byte};
      LD_HS:   ld_val = {{16{rd_half[15]}}, rd_half};
      LD_HU:   ld_val = {16'd0, rd_half};
      default: ld_val = rd_word;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM next-state and datapath
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    ld_d       = ld_q;
    store_d    = store_q;
    conflict_d = conflict_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    stall      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (re_in || we_in) begin
          stall      = 1'b1;
          addr_d     = addr[AW+1:0];
          wdata_d    = wdata;
          size_d     = size_in;
          store_d    = we_in;
          conflict_d = re_in && we_in;
          cnt_d      = 4'(WAIT_CYCLES);
          if (lbsigned_in)        ld_d = LD_BS;
          else if (lbunsigned_in) ld_d = LD_BU;
          else if (lhsigned_in)   ld_d = LD_HS;
          else if (lhunsigned_in) ld_d = LD_HU;
          else                    ld_d = LD_WORD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          done_d  = 1'b1;
          err_d   = acc_err;
          if (!store_q) begin
            rdata_d = align_err ? 32'd0 : ld_val;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      size_q     <= 2'd0;
      ld_q       <= LD_WORD;
      store_q    <= 1'b0;
      conflict_q <= 1'b0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      ld_q       <= ld_d;
      store_q    <= store_d;
      conflict_q <= conflict_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rdata   = rdata_q;
  assign done    = done_q;
  assign err_out = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        re_in = 1'b0;
  logic        we_in = 1'b0;
  logic [1:0]  size_in = 2'd0;
  logic        lbsigned_in = 1'b0;
  logic        lbunsigned_in = 1'b0;
  logic        lhsigned_in = 1'b0;
  logic        lhunsigned_in = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        err_out;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .re_in         (re_in),
    .we_in         (we_in),
    .size_in       (size_in),
    .lbsigned_in   (lbsigned_in),
    .lbunsigned_in (lbunsigned_in),
    .lhsigned_in   (lhsigned_in),
    .lhunsigned_in (lhunsigned_in),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .stall         (stall),
    .done          (done),
    .err_out       (err_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mbytes [1024];
  logic [31:0] rdata_hold = 32'd0;
  int          tests = 0;
  int          fails = 0;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference memory; byte at the lowest address is the MSB.
  task automatic model_access(input logic re, input logic we, input logic [1:0] sz,
                              input logic [3:0] lt, input logic [31:0] a,
                              input logic [31:0] wd, output exp_t e);
    logic [9:0]  b;
    logic        mis;
    logic [31:0] val;
    e.rdata = rdata_hold;
    e.err   = 1'b0;
    if (we) begin
      mis   = ((sz == 2'd1) && a[0]) || ((sz == 2'd3) && (a[1:0] != 2'b00));
      e.err = re || (sz == 2'd2) || (CHK && mis);
      if ((sz != 2'd2) && !(CHK && mis)) begin
        case (sz)
          2'd0: mbytes[a[9:0]] = wd[7:0];
          2'd1: begin
            b = {a[9:1], 1'b0};
            mbytes[b] = wd[15:8];
            mbytes[b + 10'd1] = wd[7:0];
          end
          default: begin
            b = {a[9:2], 2'b00};
            mbytes[b] = wd[31:24];
            mbytes[b + 10'd1] = wd[23:16];
            mbytes[b + 10'd2] = wd[15:8];
            mbytes[b + 10'd3] = wd[7:0];
          end
        endcase
      end
    end else begin
      if (lt[3] || lt[2]) begin
        mis = 1'b0;
        val = lt[3] ? {{24{mbytes[a[9:0]][7]}}, mbytes[a[9:0]]} : {24'd0, mbytes[a[9:0]]};
      end else if (lt[1] || lt[0]) begin
        mis = a[0];
        b   = {a[9:1], 1'b0};
        val = {16'd0, mbytes[b], mbytes[b + 10'd1]};
        if (lt[1]) val[31:16] = {16{val[15]}};
      end else begin
        mis = (a[1:0] != 2'b00);
        b   = {a[9:2], 2'b00};
        val = {mbytes[b], mbytes[b + 10'd1], mbytes[b + 10'd2], mbytes[b + 10'd3]};
      end
      e.err      = CHK && mis;
      e.rdata    = e.err ? 32'd0 : val;
      rdata_hold = e.rdata;
    end
  endtask

  task automatic access(input logic re, input logic we, input logic [1:0] sz,
                        input logic [3:0] lt, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    exp_t e;
    exp_t got;
    int   cyc;
    int   stall_cnt;
    bit   seen;
    model_access(re, we, sz, lt, a, wd, e);
    sb_q.push_back(e);
    @(negedge clk);
    re_in = re; we_in = we; size_in = sz; addr = a; wdata = wd;
    {lbsigned_in, lbunsigned_in, lhsigned_in, lhunsigned_in} = lt;
    #1;
    stall_cnt = stall ? 1 : 0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        re_in = 1'b0; we_in = 1'b0;
        {lbsigned_in, lbunsigned_in, lhsigned_in, lhunsigned_in} = 4'b0000;
      end
      cyc++;
      if (stall) stall_cnt++;
      if (done) seen = 1;
    end
    got = sb_q.pop_front();
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(cyc), 32'(W + 2));
      check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(W + 2));
      check({tag, "_rdata"}, rdata, got.rdata);
      check({tag, "_err"}, {31'd0, err_out}, {31'd0, got.err});
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    end
    $display("[TB] %s addr=%h wdata=%h rdata=%h err=%0b cycles=%0d", tag, a, wd, rdata, err_out, cyc);
  endtask

  initial begin
    // Asynchronous reset asserted between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err_out}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // lt = {lbsigned, lbunsigned, lhsigned, lhunsigned}
    access(1'b0, 1'b1, 2'd3, 4'b0000, 32'h10, 32'hDEADBEEF, "sw_10");
    access(1'b1, 1'b0, 2'd0, 4'b0000, 32'h10, 32'h0, "lw_10");
    check("spec_lw_10", rdata, 32'hDEADBEEF);

    access(1'b0, 1'b1, 2'd3, 4'b0000, 32'h20, 32'h11223344, "sw_20");
    access(1'b0, 1'b1, 2'd0, 4'b0000, 32'h21, 32'h000000AA, "sb_21");
    access(1'b1, 1'b0, 2'd0, 4'b0000, 32'h20, 32'h0, "lw_20a");
    check("spec_sb_word", rdata, 32'h11AA3344);
    access(1'b1, 1'b0, 2'd0, 4'b1000, 32'h21, 32'h0, "lb_21");
    check("spec_lb", rdata, 32'hFFFFFFAA);
    access(1'b1, 1'b0, 2'd0, 4'b0100, 32'h21, 32'h0, "lbu_21");
    check("spec_lbu", rdata, 32'h000000AA);

    access(1'b0, 1'b1, 2'd1, 4'b0000, 32'h22, 32'h00008001, "sh_22");
    access(1'b1, 1'b0, 2'd0, 4'b0000, 32'h20, 32'h0, "lw_20b");
    check("spec_sh_word", rdata, 32'h11AA8001);
    access(1'b1, 1'b0, 2'd0, 4'b0010, 32'h22, 32'h0, "lh_22");
    check("spec_lh", rdata, 32'hFFFF8001);
    access(1'b1, 1'b0, 2'd0, 4'b0001, 32'h22, 32'h0, "lhu_22");
    check("spec_lhu", rdata, 32'h00008001);
    access(1'b1, 1'b0, 2'd0, 4'b0001, 32'h20, 32'h0, "lhu_20");

    // Priority: lbunsigned beats lhsigned.
    access(1'b1, 1'b0, 2'd0, 4'b0110, 32'h21, 32'h0, "lprio_21");
    check("spec_prio", rdata, 32'h000000AA);

    // Misaligned word load.
    access(1'b1, 1'b0, 2'd0, 4'b0000, 32'h13, 32'h0, "lw_13");
    check("spec_lw_13", rdata, CHK ? 32'd0 : 32'hDEADBEEF);

    // Stores leave rdata alone; reserved size and re+we both report errors.
    access(1'b0, 1'b1, 2'd2, 4'b0000, 32'h20, 32'hFFFFFFFF, "sres_20");
    access(1'b1, 1'b0, 2'd0, 4'b0000, 32'h20, 32'h0, "lw_20c");
    access(1'b1, 1'b1, 2'd3, 4'b0000, 32'h50, 32'hCAFEF00D, "srw_50");
    access(1'b1, 1'b0, 2'd0, 4'b0000, 32'h50, 32'h0, "lw_50");
    access(1'b0, 1'b1, 2'd1, 4'b0000, 32'h53, 32'h00001234, "sh_53");
    access(1'b1, 1'b0, 2'd0, 4'b0000, 32'h50, 32'h0, "lw_50b");

    // Reset in WAIT abandons the store.
    access(1'b0, 1'b1, 2'd3, 4'b0000, 32'h40, 32'h12345678, "sw_40");
    @(negedge clk);
    re_in = 1'b0; we_in = 1'b1; size_in = 2'd3; addr = 32'h40; wdata = 32'h5;
    @(posedge clk);
    #1;
    we_in = 1'b0;
    check("rstw_in_wait", {31'd0, stall}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstw_stall", {31'd0, stall}, 32'd0);
    check("rstw_done", {31'd0, done}, 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    rdata_hold = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) begin
      @(posedge clk);
      #1;
      check("rstw_no_done", {31'd0, done}, 32'd0);
    end
    $display("[TB] reset_in_wait addr=00000040 rdata=%h", rdata);
    access(1'b1, 1'b0, 2'd0, 4'b0000, 32'h40, 32'h0, "lw_40");
    check("spec_lw_40", rdata, 32'h12345678);

    // Address wrap-around at 4*DEPTH_WORDS bytes.
    access(1'b0, 1'b1, 2'd3, 4'b0000, 32'h400, 32'h7, "sw_400");
    access(1'b1, 1'b0, 2'd0, 4'b0000, 32'h0, 32'h0, "lw_0");
    check("spec_wrap", rdata, 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
